// File: rtl/wall_scheduler.sv
// wall_scheduler: LFSR-driven random placement of 2 or 4 non-overlapping
// 64x64 walls on a 640x480 field, published atomically on a frame tick.
// Optional build macro: WALL_SCHED_OVERLAP_CHECK_EN enables the pairwise
// overlap rejection; without it only the screen-range test is applied and
// error never sets.

// Pairwise overlap test of a candidate against one shadow slot.
module wall_overlap (
   input  logic [9:0] ax,
   input  logic [9:0] ay,
   input  logic [9:0] bx,
   input  logic [9:0] by,
   input  logic       bvalid,
   output logic       hit
);
   logic [10:0] ea, eb, fa, fb, dx, dy;

   // 11-bit unsigned distance on each axis; overlap when both are under 64
   always_comb begin
      ea  = {1'b0, ax};
      eb  = {1'b0, bx};
      fa  = {1'b0, ay};
      fb  = {1'b0, by};
      dx  = (ea >= eb) ? (ea - eb) : (eb - ea);
      dy  = (fa >= fb) ? (fa - fb) : (fb - fa);
      hit = bvalid && (dx < 11'd64) && (dy < 11'd64);
   end
endmodule

module wall_scheduler (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic        start,
   input  logic        num_walls,
   input  logic [15:0] seed,
   output logic [9:0]  X1,
   output logic [9:0]  X2,
   output logic [9:0]  X3,
   output logic [9:0]  X4,
   output logic [9:0]  Y1,
   output logic [9:0]  Y2,
   output logic [9:0]  Y3,
   output logic [9:0]  Y4,
   output logic [3:0]  wall_valid,
   output logic        busy,
   output logic        done,
   output logic        error
);
   localparam int NUM_SLOTS = 4;

`ifdef WALL_SCHED_OVERLAP_CHECK_EN
   localparam bit OVL_EN = 1'b1;
`else
   localparam bit OVL_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, GEN, CHECK, NEXT, WAIT_FRAME} state_t;

   state_t                       state, state_nxt;
   logic [15:0]                  lfsr, lfsr_step;
   logic [2:0]                   fsync;
   logic                         frame_rise;
   logic                         nw_q;
   logic [1:0]                   slot;
   logic [4:0]                   attempt;
   logic [9:0]                   cand_x, cand_y;
   logic [NUM_SLOTS-1:0][9:0]    sh_x, sh_y, pub_x, pub_y;
   logic [NUM_SLOTS-1:0]         sh_valid;
   logic [NUM_SLOTS-1:0]         hit;
   logic                         in_range, accept, last_slot;
   logic                         start_acc, gen_cand, do_accept, do_reject;
   logic                         adv_slot, publish;

   // Fibonacci taps 16,14,13,11; an all-zero result is pulled back to the seed value
   always_comb begin
      lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (lfsr_step == 16'h0) lfsr_step = 16'hACE1;
   end

   // LFSR free-runs every cycle; a nonzero seed overrides it on an accepted start
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                      lfsr <= 16'hACE1;
      else if (start_acc && seed != '0)  lfsr <= seed;
      else                               lfsr <= lfsr_step;
   end

   // Two-flop synchronizer plus previous-value flop for frame_clk edge detection
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) fsync <= '0;
      else          fsync <= {fsync[1:0], frame_clk};
   end

   assign frame_rise = fsync[1] & ~fsync[2];

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_ovl
      wall_overlap u_ovl (
         .ax     (cand_x),
         .ay     (cand_y),
         .bx     (sh_x[i]),
         .by     (sh_y[i]),
         .bvalid (sh_valid[i]),
         .hit    (hit[i])
      );
   end

   assign in_range  = (cand_x <= 10'd575) && (cand_y <= 10'd415);
   assign accept    = in_range && !(OVL_EN && (|hit));
   assign last_slot = nw_q ? (slot == 2'd3) : (slot == 2'd1);
   assign busy      = (state != IDLE);

   // FSM state register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state and datapath strobes
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      gen_cand  = 1'b0;
      do_accept = 1'b0;
      do_reject = 1'b0;
      adv_slot  = 1'b0;
      publish   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = GEN;
            end
         end
         GEN: begin
            gen_cand  = 1'b1;
            state_nxt = CHECK;
         end
         CHECK: begin
            if (accept) begin
               do_accept = 1'b1;
               state_nxt = NEXT;
            end else begin
               do_reject = 1'b1;
               state_nxt = (attempt == 5'd31) ? NEXT : GEN;
            end
         end
         NEXT: begin
            if (last_slot) state_nxt = WAIT_FRAME;
            else begin
               adv_slot  = 1'b1;
               state_nxt = GEN;
            end
         end
         WAIT_FRAME: begin
            if (frame_rise) begin
               publish   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Placement datapath: latched config, candidate, shadow slots, attempts, sticky error
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         nw_q     <= 1'b0;
         slot     <= '0;
         attempt  <= '0;
         cand_x   <= '0;
         cand_y   <= '0;
         sh_x     <= '0;
         sh_y     <= '0;
         sh_valid <= '0;
         error    <= 1'b0;
      end else begin
         if (start_acc) begin
            nw_q     <= num_walls;
            slot     <= '0;
            attempt  <= '0;
            sh_x     <= '0;
            sh_y     <= '0;
            sh_valid <= '0;
            error    <= 1'b0;
         end
         if (gen_cand) begin
            cand_x <= lfsr[9:0];
            cand_y <= {1'b0, lfsr[15:7]};
         end
         if (do_accept) begin
            sh_x[slot]     <= cand_x;
            sh_y[slot]     <= cand_y;
            sh_valid[slot] <= 1'b1;
            attempt        <= '0;
         end
         // 32nd rejection gives up on this slot; it stays invalid
         if (do_reject) begin
            if (attempt == 5'd31) begin
               attempt <= '0;
               if (OVL_EN) error <= 1'b1;
            end else begin
               attempt <= attempt + 5'd1;
            end
         end
         if (adv_slot) slot <= slot + 2'd1;
      end
   end

   // Visible layout changes only in the publish cycle, so a frame never tears
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pub_x      <= '0;
         pub_y      <= '0;
         wall_valid <= '0;
         done       <= 1'b0;
      end else begin
         done <= publish;
         if (publish) begin
            pub_x      <= sh_x;
            pub_y      <= sh_y;
            wall_valid <= sh_valid;
         end
      end
   end

   assign X1 = pub_x[0];
   assign X2 = pub_x[1];
   assign X3 = pub_x[2];
   assign X4 = pub_x[3];
   assign Y1 = pub_y[0];
   assign Y2 = pub_y[1];
   assign Y3 = pub_y[2];
   assign Y4 = pub_y[3];

endmodule

// File: tb/tb_wall_scheduler.sv
// Randomized bench for wall_scheduler against a rule-level placement model.
`timescale 1ns/1ps
module tb_wall_scheduler;
   logic        Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, start = 1'b0, num_walls = 1'b0;
   logic [15:0] seed = 16'h0;
   logic [9:0]  X1, X2, X3, X4, Y1, Y2, Y3, Y4;
   logic [3:0]  wall_valid;
   logic        busy, done, error;

   int vectors = 0, miscompares = 0;

`ifdef WALL_SCHED_OVERLAP_CHECK_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   // model results for the most recent start
   logic [9:0] m_x [4];
   logic [9:0] m_y [4];
   logic [3:0] m_valid;
   logic       m_err;
   int         m_cycles;

   wall_scheduler dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
      .num_walls(num_walls), .seed(seed),
      .X1(X1), .X2(X2), .X3(X3), .X4(X4), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4),
      .wall_valid(wall_valid), .busy(busy), .done(done), .error(error)
   );

   always #10 Clk = ~Clk;

   function automatic logic [15:0] lstep(input logic [15:0] v);
      logic [15:0] n;
      n = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      if (n == 16'h0) n = 16'hACE1;
      return n;
   endfunction

   function automatic int iabs(input int a);
      return (a < 0) ? -a : a;
   endfunction

   // Placement by the rules: each attempt costs 2 cycles (2 LFSR steps),
   // each slot ends with one NEXT cycle (1 step).
   task automatic model(input logic [15:0] sd, input logic nw);
      logic [15:0] v;
      int cx, cy, tries, n;
      bit ok;
      v = sd; m_cycles = 0; m_valid = '0; m_err = 1'b0;
      for (int s = 0; s < 4; s++) begin m_x[s] = '0; m_y[s] = '0; end
      n = nw ? 4 : 2;
      for (int s = 0; s < n; s++) begin
         tries = 0;
         while (tries < 32) begin
            cx = int'(v[9:0]);
            cy = int'(v[15:7]);
            ok = (cx <= 575) && (cy <= 415);
            if (OVL)
               for (int k = 0; k < 4; k++)
                  if (m_valid[k] && iabs(cx - int'(m_x[k])) < 64 && iabs(cy - int'(m_y[k])) < 64) ok = 1'b0;
            v = lstep(lstep(v));
            m_cycles += 2;
            if (ok) begin
               m_x[s] = cx[9:0]; m_y[s] = cy[9:0]; m_valid[s] = 1'b1;
               break;
            end
            tries++;
         end
         if (tries == 32 && OVL) m_err = 1'b1;
         v = lstep(v);
         m_cycles += 1;
      end
   endtask

   function automatic logic [84:0] obs_vec();
      return {X1, Y1, X2, Y2, X3, Y3, X4, Y4, wall_valid, error};
   endfunction

   function automatic logic [84:0] exp_vec();
      return {m_x[0], m_y[0], m_x[1], m_y[1], m_x[2], m_y[2], m_x[3], m_y[3], m_valid, m_err};
   endfunction

   // range, unused-slot zeroing and (when enabled) pairwise separation of published walls
   function automatic bit legal();
      logic [9:0] xs [4];
      logic [9:0] ys [4];
      bit ok;
      ok = 1'b1;
      xs = '{X1, X2, X3, X4};
      ys = '{Y1, Y2, Y3, Y4};
      for (int i = 0; i < 4; i++) begin
         if (wall_valid[i] && (xs[i] > 10'd575 || ys[i] > 10'd415)) ok = 1'b0;
         if (!wall_valid[i] && (xs[i] != '0 || ys[i] != '0)) ok = 1'b0;
         if (OVL)
            for (int j = i + 1; j < 4; j++)
               if (wall_valid[i] && wall_valid[j] &&
                   iabs(int'(xs[i]) - int'(xs[j])) < 64 && iabs(int'(ys[i]) - int'(ys[j])) < 64) ok = 1'b0;
      end
      return ok;
   endfunction

   // Pulse start for one cycle; returns at the negedge after the accepting edge
   task automatic kick(input logic [15:0] sd, input logic nw);
      @(negedge Clk); seed = sd; num_walls = nw; start = 1'b1;
      @(negedge Clk); start = 1'b0;
      model(sd, nw);
   endtask

   // Wait for the model's WAIT_FRAME entry, raise frame_clk, watch done in a bounded window
   task automatic frame_wait(input int skip, output int ndone, output int at, output bit pre_ok);
      repeat (m_cycles - skip) @(negedge Clk);
      pre_ok = (busy === 1'b1) && (done === 1'b0);
      frame_clk = 1'b1;
      ndone = 0; at = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge Clk);
         if (done === 1'b1) begin ndone++; if (at == 0) at = i; end
      end
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_reset();
      #5;
      vectors++;
      if ({obs_vec(), busy, done} !== 87'h0) begin
         miscompares++; $display("FAIL reset_state: got %h expected 0", {obs_vec(), busy, done});
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if ({obs_vec(), busy, done} !== 87'h0) begin
         miscompares++; $display("FAIL reset_held: got %h expected 0", {obs_vec(), busy, done});
      end
      Reset_n = 1'b1;
   endtask

   task automatic test_basic();
      int nd, at; bit pre;
      kick(16'h1234, 1'b0);
      frame_wait(0, nd, at, pre);
      vectors++;
      if (!pre) begin miscompares++; $display("FAIL basic_busy_before_frame: busy=%b done=%b expected 1/0", busy, done); end
      vectors++;
      if (nd != 1 || at != 3) begin miscompares++; $display("FAIL basic_done: pulses=%0d at=%0d expected 1 at 3", nd, at); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL basic_layout: got %h expected %h", obs_vec(), exp_vec()); end
      vectors++;
      if (wall_valid !== 4'b0011 || !legal()) begin
         miscompares++; $display("FAIL basic_legal: valid=%b X1=%0d Y1=%0d X2=%0d Y2=%0d expected 0011 in range", wall_valid, X1, Y1, X2, Y2);
      end
   endtask

   task automatic test_frame_hold();
      logic [83:0] snap; int bad, nd, at; bit pre;
      snap = obs_vec()[84:1];
      kick(16'($urandom_range(1, 65535)), 1'b1);
      bad = 0;
      repeat (1000) begin
         @(negedge Clk);
         if (busy !== 1'b1 || done !== 1'b0 || obs_vec()[84:1] !== snap) bad++;
      end
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL hold_no_publish: %0d bad cycles expected 0", bad); end
      frame_wait(m_cycles, nd, at, pre);
      vectors++;
      if (nd != 1 || at > 4) begin miscompares++; $display("FAIL hold_done: pulses=%0d at=%0d expected 1 within 4", nd, at); end
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL hold_layout: got %h expected %h", obs_vec(), exp_vec()); end
   endtask

   task automatic test_ignore_start();
      int nd, at; bit pre;
      kick(16'($urandom_range(1, 65535)), 1'b1);
      @(negedge Clk); start = 1'b1; num_walls = 1'b0; seed = 16'h5A5A;
      @(negedge Clk); start = 1'b0;
      frame_wait(2, nd, at, pre);
      vectors++;
      if (nd != 1 || at != 3) begin miscompares++; $display("FAIL ignore_done: pulses=%0d at=%0d expected 1 at 3", nd, at); end
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL ignore_layout: got %h expected %h", obs_vec(), exp_vec()); end
   endtask

   task automatic test_frame_outside();
      int nd, at, early; bit pre;
      kick(16'($urandom_range(1, 65535)), 1'b0);
      frame_clk = 1'b1;
      early = 0;
      repeat (m_cycles + 6) begin @(negedge Clk); if (done === 1'b1) early++; end
      vectors++;
      if (early != 0 || busy !== 1'b1) begin miscompares++; $display("FAIL stale_edge: done pulses=%0d busy=%b expected 0/1", early, busy); end
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      frame_wait(m_cycles, nd, at, pre);
      vectors++;
      if (nd != 1 || at != 3) begin miscompares++; $display("FAIL fresh_edge: pulses=%0d at=%0d expected 1 at 3", nd, at); end
   endtask

   task automatic test_determinism();
      logic [84:0] o1; logic [15:0] sd; int nd, at; bit pre;
      sd = 16'($urandom_range(1, 65535));
      kick(sd, 1'b1); frame_wait(0, nd, at, pre); o1 = obs_vec();
      repeat (5) @(negedge Clk);
      kick(sd, 1'b1); frame_wait(0, nd, at, pre);
      vectors++;
      if (obs_vec() !== o1) begin miscompares++; $display("FAIL determinism: got %h expected %h", obs_vec(), o1); end
      vectors++;
      if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL determinism_model: got %h expected %h", obs_vec(), exp_vec()); end
   endtask

   task automatic test_reset_mid_check();
      int late;
      kick(16'($urandom_range(1, 65535)), 1'b1);
      @(negedge Clk);           // CHECK cycle
      #2 Reset_n = 1'b0;
      #1;
      vectors++;
      if ({obs_vec(), busy, done} !== 87'h0) begin
         miscompares++; $display("FAIL reset_mid_check: got %h expected 0", {obs_vec(), busy, done});
      end
      late = 0;
      repeat (4) begin @(negedge Clk); if (done !== 1'b0 || busy !== 1'b0) late++; end
      vectors++;
      if (late != 0) begin miscompares++; $display("FAIL reset_abort: %0d bad cycles expected 0", late); end
      Reset_n = 1'b1;
   endtask

   task automatic test_scoreboard();
      int nd, at; bit pre;
      for (int n = 0; n < 1000; n++) begin
         kick(16'($urandom_range(1, 65535)), 1'($urandom_range(0, 1)));
         frame_wait(0, nd, at, pre);
         vectors++;
         if (!pre || nd != 1 || at != 3) begin
            miscompares++; $display("FAIL sb_timing run %0d: pre=%b pulses=%0d at=%0d expected 1/1/3", n, pre, nd, at);
         end
         vectors++;
         if (obs_vec() !== exp_vec()) begin miscompares++; $display("FAIL sb_layout run %0d: got %h expected %h", n, obs_vec(), exp_vec()); end
         vectors++;
         if (!legal()) begin miscompares++; $display("FAIL sb_legal run %0d: got %h expected legal layout", n, obs_vec()); end
         if (!OVL) begin
            vectors++;
            if (error !== 1'b0) begin miscompares++; $display("FAIL sb_error run %0d: got %b expected 0", n, error); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frame_hold();
      test_ignore_start();
      test_frame_outside();
      test_determinism();
      test_reset_mid_check();
      test_basic();
      test_scoreboard();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wall_scheduler.md
WALL_SCHEDULER -- requirements
Module: wall_scheduler

Interface
REQ-001 SHALL have ports: Clk  in  1  system clock (50 MHz); one clock domain only.
REQ-002 SHALL have ports: Reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: frame_clk  in  1  frame tick (~60 Hz), asynchronous to Clk.
REQ-004 SHALL have ports: start  in  1  request a new wall layout (level pulse, sampled on Clk).
REQ-005 SHALL have ports: num_walls  in  1  0 = 2 walls (slots 1,2); 1 = 4 walls (slots 1-4).
REQ-006 SHALL have ports: seed  in  16  LFSR seed, loaded on accepted start when nonzero.
REQ-007 SHALL have ports: X1..X4, Y1..Y4  out  10 each  published wall top-left corners.
REQ-008 SHALL have ports: wall_valid  out  4  bit i-1 = slot i holds a placed wall.
REQ-009 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; error  out  1  sticky placement failure.

Function
REQ-010 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every Clk; reset value 16'hACE1; all-zero state forced to 16'hACE1.
REQ-011 SHALL use FSM states IDLE, GEN, CHECK, NEXT, WAIT_FRAME.
REQ-012 IDLE: start=1 -> GEN; latch num_walls; load seed if nonzero; clear shadow slots, attempt counter, error; busy=1 from next cycle.
REQ-013 GEN (1 cycle): candidate X = lfsr[9:0], Y = {1'b0, lfsr[15:7]}.
REQ-014 CHECK (1 cycle): accept iff X <= 575, Y <= 415, and no overlap with any accepted shadow slot; overlap = |Xa-Xb| < 64 AND |Ya-Yb| < 64, computed 11-bit unsigned.
REQ-015 CHECK accept: write shadow slot, set shadow valid bit, clear attempt counter -> NEXT.
REQ-016 CHECK reject: increment 5-bit attempt counter -> GEN; on 32nd rejection of same slot, slot left invalid, error=1, -> NEXT.
REQ-017 NEXT: if current slot is last (2 or 4 per latched num_walls) -> WAIT_FRAME, else slot+1 -> GEN.
REQ-018 frame_clk SHALL pass a 2-flop synchronizer plus rising-edge detector in Clk domain.
REQ-019 WAIT_FRAME: on first detected frame_clk rising edge, copy shadow X/Y/valid to outputs in one Clk, pulse done for exactly that cycle, drop busy same cycle, -> IDLE.
REQ-020 Outputs X/Y/wall_valid SHALL change only in the WAIT_FRAME publish cycle (no mid-frame tearing).
REQ-021 start while busy=1 SHALL be ignored, with no effect on state or latched num_walls.
REQ-022 Frame edge outside WAIT_FRAME SHALL be ignored (not queued).
REQ-023 Unused slots (3,4 when num_walls=0) SHALL publish X=Y=0, valid=0.
REQ-024 Worst-case latency start->WAIT_FRAME: 4 slots x 32 attempts x 2 cycles + 4 NEXT cycles = 260 Clk.

Reset
REQ-025 Reset_n=0 SHALL immediately force: FSM IDLE, LFSR 16'hACE1, all X/Y 0, wall_valid 0, busy 0, done 0, error 0, shadow and synchronizer flops 0.
REQ-026 Reset asserted mid-placement or in WAIT_FRAME SHALL abort with no publish; outputs return to reset values.
REQ-027 After Reset_n deasserts, first start accepted on the first Clk edge where it is sampled high.

Configuration
REQ-028 Macro WALL_SCHED_OVERLAP_CHECK_EN: defined -> overlap test per REQ-014 active.
REQ-029 WALL_SCHED_OVERLAP_CHECK_EN undefined -> only range test applied; error never sets; all other timing unchanged.

Verification
REQ-030 Reset_n low mid-CHECK -> all outputs 0, busy 0 within the same cycle; no done pulse.
REQ-031 start=1, num_walls=0, seed=16'h1234, frame_clk toggling -> one done pulse; wall_valid=4'b0011; X1,X2 <= 575; Y1,Y2 <= 415; slots 1,2 non-overlapping; X3=Y3=X4=Y4=0.
REQ-032 num_walls=1, frame_clk held low 1000 Clk -> busy stays 1, done 0, outputs unchanged; first frame_clk rise -> done pulse and wall_valid=4'b1111 within 4 Clk.
REQ-033 start re-pulsed while busy with num_walls flipped 1->0 -> ignored; published layout uses the originally latched num_walls.
REQ-034 Scoreboard over 1000 starts with random seeds -> every published valid pair non-overlapping and in range; with macro undefined, error always 0.
REQ-035 Repeated start with same nonzero seed and identical frame_clk phase -> identical X/Y outputs (determinism).
